odd_even_arb: RTL and testbench
===============================

Name: odd_even_arb

Overview:
- Shares one odd_even parity classifier (4-bit num -> even/odd flags) between two requesters.
- Requesters use valid/ready handshakes. A round-robin arbiter grants one request per cycle.
- The block registers the classified result with requester ID for a single consumer, with backpressure.
- Keeps per-class saturating counters of processed numbers, for status and debug.

Parameters:
- W, 4, number width (classifier width; only 4 is verified).
- CW, 8, width of the odd/even statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a number.
- req0_num  in  W  requester 0 number.
- req0_ready  out  1  requester 0 accepted this cycle (combinational grant).
- req1_valid  in  1  requester 1 has a number.
- req1_num  in  W  requester 1 number.
- req1_ready  out  1  requester 1 accepted this cycle.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer takes the result.
- res_id  out  1  requester that supplied the result.
- res_num  out  W  the classified number.
- res_even  out  1  res_num LSB == 0.
- res_odd  out  1  res_num LSB == 1.
- even_cnt  out  CW  count of even results delivered (saturating).
- odd_cnt  out  CW  count of odd results delivered (saturating).

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state EMPTY, rr_ptr = 0 (requester 0 has priority first). Reset mid-transfer discards the held result and clears the counters.
- FSM states:
  - EMPTY: no held result.
  - FULL: result held, res_valid = 1.
- can_accept = (state == EMPTY) || (res_ready && state == FULL). This is a one-deep pipeline with same-cycle replace.
- Arbitration (combinational):
  - Only one valid requester: it wins.
  - Both valid: the winner is rr_ptr.
  - reqN_ready = can_accept && winner == N. Never both ready in the same cycle.
- Accept edge:
  - The result register loads {id, num, even, odd}, with even/odd taken from the classifier on the granted num.
  - rr_ptr <= ~id.
  - State -> FULL.
- Latency: a number accepted at edge N is visible on res_* from edge N.
- Delivery (res_valid && res_ready):
  - If nothing is accepted that cycle, state -> EMPTY and res_valid falls.
  - If a new request is accepted the same cycle, the state stays FULL with new contents. This gives back-to-back throughput of 1 per cycle.
- Stability: res_* must not change while res_valid && !res_ready.
- Counters: at each delivery, even_cnt or odd_cnt increments by 1. Each saturates at 2^CW-1 and never wraps. Exactly one of the two increments per delivery.
- Invariants:
  - res_even == ~res_odd whenever res_valid.
  - res_* are 0 after reset until the first accept.
- A request that is not granted must be held by its requester, valid/num stable, until ready.

Decomposition:
- Shared header or package holds:
  - state encodings ST_EMPTY = 1'b0, ST_FULL = 1'b1;
  - ID_REQ0 = 1'b0, ID_REQ1 = 1'b1;
  - default widths W = 4, CW = 8.
- One sub-module, the existing odd_even classifier (ports num, even, odd), instantiated once on the arbiter mux output. Arbiter, FSM and counters live in odd_even_arb.

Test Plan:
- Reset, then req0 only with nums 0..9, res_ready = 1 -> one result per cycle, id 0, even/odd alternating starting even; afterwards even_cnt = 5, odd_cnt = 5.
- Both valid continuously (req0 = 4'b0011, req1 = 4'b0100), res_ready = 1 -> ids alternate 0,1,0,1; req0 is granted first after reset; odd_cnt and even_cnt rise in step.
- Result held: accept 4'b0111, res_ready = 0 for 3 cycles while req1 is valid -> res_* stays stable (num 7, odd 1), req1_ready = 0. Raise res_ready -> req1 is accepted in the same cycle, and the new result appears on the next edge.
- Saturation: CW = 2, send 5 even numbers -> even_cnt goes 1,2,3,3,3; odd_cnt stays 0.
- Asynchronous reset asserted mid-cycle while FULL with counters nonzero -> outputs go to 0 immediately, without waiting for clk. After release, req1 and req0 valid together -> req0 is granted first.
- Bubble: req0 valid every other cycle, res_ready = 1 -> res_valid toggles 1/0 and the state returns to EMPTY between numbers.

Source files
------------

// File: rtl/odd_even_arb_pkg.sv
// Shared encodings and default widths for the odd/even arbiter slice.
package odd_even_arb_pkg;

  localparam int unsigned W_DEF  = 4;
  localparam int unsigned CW_DEF = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/odd_even_arb_cls.sv
// Parity classifier: flags whether num is even or odd.
module odd_even_arb_cls #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] num,
  output logic         even,
  output logic         odd
);

  assign odd  = num[0];
  assign even = ~num[0];

endmodule

// File: rtl/odd_even_arb.sv
// Two-requester round-robin front end sharing one parity classifier,
// with a one-deep result register and saturating odd/even statistics.
module odd_even_arb
  import odd_even_arb_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_num,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_num,
  output logic          req1_ready,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_id,
  output logic [W-1:0]  res_num,
  output logic          res_even,
  output logic          res_odd,
  output logic [CW-1:0] even_cnt,
  output logic [CW-1:0] odd_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t         state;
  state_t         state_nx;
  logic           rr_ptr;
  logic           winner_c;
  logic           any_c;
  logic           can_accept_c;
  logic           accept_c;
  logic           deliver_c;
  logic [W-1:0]   mux_num_c;
  logic           cls_even;
  logic           cls_odd;

  // Arbitration: a lone requester wins; on contention rr_ptr decides.
  always_comb begin
    winner_c     = ID_REQ0;
    any_c        = req0_valid | req1_valid;
    can_accept_c = (state == ST_EMPTY) || (res_ready && (state == ST_FULL));
    deliver_c    = (state == ST_FULL) && res_ready;
    if (req0_valid && req1_valid) begin
      winner_c = rr_ptr;
    end else if (req1_valid) begin
      winner_c = ID_REQ1;
    end
    accept_c  = can_accept_c && any_c;
    mux_num_c = (winner_c == ID_REQ1) ? req1_num : req0_num;
  end

  odd_even_arb_cls #(.W(W)) u_cls (
    .num  (mux_num_c),
    .even (cls_even),
    .odd  (cls_odd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // A same-cycle accept overrides delivery so throughput stays at one per cycle.
  always_comb begin
    state_nx = state;
    if (accept_c) begin
      state_nx = ST_FULL;
    end else if (deliver_c) begin
      state_nx = ST_EMPTY;
    end
  end

  always_comb begin
    req0_ready = accept_c && (winner_c == ID_REQ0);
    req1_ready = accept_c && (winner_c == ID_REQ1);
    res_valid  = (state == ST_FULL);
  end

  // Result register loads only on accept, so it holds steady under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_id   <= 1'b0;
      res_num  <= '0;
      res_even <= 1'b0;
      res_odd  <= 1'b0;
      rr_ptr   <= ID_REQ0;
    end else if (accept_c) begin
      res_id   <= winner_c;
      res_num  <= mux_num_c;
      res_even <= cls_even;
      res_odd  <= cls_odd;
      rr_ptr   <= ~winner_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      even_cnt <= '0;
      odd_cnt  <= '0;
    end else if (deliver_c) begin
      if (res_even) begin
        if (even_cnt != CNT_MAX) even_cnt <= even_cnt + CW'(1);
      end else begin
        if (odd_cnt != CNT_MAX) odd_cnt <= odd_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_odd_even_arb.sv
// Self-checking bench: directed scenarios plus constrained-random traffic
// against a transaction-level model of the arbiter and result slot.
module tb_odd_even_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic       req1_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic [3:0] req0_num = '0;
  logic [3:0] req1_num = '0;

  logic       req0_ready, req1_ready, res_valid, res_id, res_even, res_odd;
  logic [3:0] res_num;
  logic [7:0] even_cnt, odd_cnt;

  logic       d2_req0_ready, d2_req1_ready, d2_res_valid, d2_res_id, d2_res_even, d2_res_odd;
  logic [3:0] d2_res_num;
  logic [1:0] d2_even_cnt, d2_odd_cnt;

  odd_even_arb #(.W(4), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_num(req0_num), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_num(req1_num), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_num(res_num), .res_even(res_even), .res_odd(res_odd),
    .even_cnt(even_cnt), .odd_cnt(odd_cnt)
  );

  odd_even_arb #(.W(4), .CW(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_num(req0_num), .req0_ready(d2_req0_ready),
    .req1_valid(req1_valid), .req1_num(req1_num), .req1_ready(d2_req1_ready),
    .res_valid(d2_res_valid), .res_ready(res_ready), .res_id(d2_res_id),
    .res_num(d2_res_num), .res_even(d2_res_even), .res_odd(d2_res_odd),
    .even_cnt(d2_even_cnt), .odd_cnt(d2_odd_cnt)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: slot occupancy, held transaction, who was served last, delivery tallies.
  bit m_valid  = 0;
  bit m_loaded = 0;
  int m_id     = 0;
  int m_num    = 0;
  int m_last   = 1;
  int ec = 0, oc = 0, ec2 = 0, oc2 = 0;
  bit cmp_en   = 0;

  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_loaded = 0; m_id = 0; m_num = 0; m_last = 1;
      ec = 0; oc = 0; ec2 = 0; oc2 = 0;
    end else begin
      bit room, deliver, any;
      int win;
      room    = !m_valid || res_ready;
      deliver = m_valid && res_ready;
      any     = req0_valid || req1_valid;
      win     = pick(req0_valid, req1_valid, m_last);
      if (deliver) begin
        if (m_num % 2 == 0) begin
          ec  = (ec  < 255) ? ec  + 1 : ec;
          ec2 = (ec2 < 3)   ? ec2 + 1 : ec2;
        end else begin
          oc  = (oc  < 255) ? oc  + 1 : oc;
          oc2 = (oc2 < 3)   ? oc2 + 1 : oc2;
        end
      end
      if (room && any) begin
        m_valid  = 1;
        m_loaded = 1;
        m_id     = win;
        m_num    = (win == 1) ? int'(req1_num) : int'(req0_num);
        m_last   = win;
      end else if (deliver) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit room, any;
      int win;
      room = !m_valid || res_ready;
      any  = req0_valid || req1_valid;
      win  = pick(req0_valid, req1_valid, m_last);
      chk("req0_ready", req0_ready, room && any && win == 0);
      chk("req1_ready", req1_ready, room && any && win == 1);
      chk("res_valid", res_valid, m_valid);
      if (m_valid || !m_loaded) begin
        chk("res_id",   res_id,   m_id);
        chk("res_num",  res_num,  m_num);
        chk("res_even", res_even, m_loaded && (m_num % 2 == 0));
        chk("res_odd",  res_odd,  m_loaded && (m_num % 2 == 1));
      end
      chk("even_cnt", even_cnt, ec);
      chk("odd_cnt",  odd_cnt,  oc);
      chk("d2_even_cnt", d2_even_cnt, ec2);
      chk("d2_odd_cnt",  d2_odd_cnt,  oc2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  bit g0, g1;

  initial begin
    tick();
    cmp_en = 1;

    // Single requester streaming 0..9
    do_reset();
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_num", res_num, 0);
    chk("rst_even_cnt", even_cnt, 0);
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1;
      req0_num   = 4'(i);
      tick();
      if (i == 0) begin
        #1;
        chk("p1_first_num", res_num, 0);
        chk("p1_first_even", res_even, 1);
        chk("p1_first_id", res_id, 0);
      end
    end
    req0_valid = 1'b0;
    tick();
    #1;
    chk("p1_even_total", even_cnt, 5);
    chk("p1_odd_total", odd_cnt, 5);

    // Both requesters continuously valid
    do_reset();
    res_ready  = 1'b1;
    req0_valid = 1'b1; req0_num = 4'b0011;
    req1_valid = 1'b1; req1_num = 4'b0100;
    #1;
    chk("p2_first_grant0", req0_ready, 1);
    chk("p2_first_grant1", req1_ready, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      chk("p2_id_alt", res_id, i % 2);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    #1;
    chk("p2_odd_total", odd_cnt, 4);
    chk("p2_even_total", even_cnt, 4);

    // Saturation on the narrow-counter instance
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1;
      req0_num   = 4'(2 * i);
      tick();
      #1;
      if (i > 0) chk("sat_step", d2_even_cnt, (i > 3) ? 3 : i);
    end
    req0_valid = 1'b0;
    tick();
    #1;
    chk("sat_final", d2_even_cnt, 3);
    chk("sat_wide", even_cnt, 5);
    chk("sat_odd", d2_odd_cnt, 0);

    // Held result under backpressure, then same-cycle replace
    do_reset();
    req0_valid = 1'b1; req0_num = 4'b0111;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_num = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_num", res_num, 7);
      chk("hold_odd", res_odd, 1);
      chk("hold_req1_ready", req1_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("release_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    res_ready  = 1'b0;
    #1;
    chk("replace_id", res_id, 1);
    chk("replace_num", res_num, 4);
    chk("replace_even", res_even, 1);
    chk("replace_odd_cnt", odd_cnt, 1);

    // Asynchronous reset while FULL with nonzero counters
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_odd_cnt", odd_cnt, 0);
    chk("arst_num", res_num, 0);
    chk("arst_even", res_even, 0);
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_num = 4'd1;
    req1_valid = 1'b1; req1_num = 4'd2;
    res_ready  = 1'b1;
    #1;
    chk("arst_prio0", req0_ready, 1);
    tick();
    tick();
    #1;
    chk("arst_second_id", res_id, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Bubbles: requester 0 valid every other cycle
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_valid = (i % 2 == 0);
      req0_num   = 4'(i + 3);
      #1;
      if (i > 0) chk("bubble_valid", res_valid, i % 2);
      tick();
    end
    req0_valid = 1'b0;
    tick();

    // Random traffic; requesters hold valid/num until granted
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      @(posedge clk);
      #1;
      if (!req0_valid || g0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_num   = 4'($urandom);
      end
      if (!req1_valid || g1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_num   = 4'($urandom);
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
